// File: rtl/bit_serializer_if.sv
// Handshake bundle between a word producer, the serializer and the bit-select collector.
//   in_data/in_valid/in_ready : word input handshake
//   ser_bit/ser_idx/ser_valid/ser_ready : per-bit output handshake with position tag
//   done/busy : frame status
// The slave modport is the serializer's view; master is the producer/collector side.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic [IDX_W-1:0] ser_idx;
  logic             ser_valid;
  logic             ser_ready;
  logic             done;
  logic             busy;

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_bit, ser_idx, ser_valid, done, busy
  );

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_bit, ser_idx, ser_valid, done, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter. Accepts one WIDTH-bit word in IDLE and emits it one bit
// per transfer, tagging each bit with its index so the far-end collector can steer it.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : bit_serializer_if.slave (word input, tagged bit output, done/busy status)
// Parameters: WIDTH (>= 2) word width; MSB_FIRST selects emission order.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic            clk,
  input logic            reset,
  bit_serializer_if.slave bus
);
  localparam int unsigned     IDX_W     = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? IDX_W'(WIDTH - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             in_ready_q;
  logic             ser_valid_q;
  logic             ser_bit_q;
  logic             done_q;
  logic             busy_q;

  // Next position in emission order; only used when idx is not the last position,
  // so it never leaves 0..WIDTH-1.
  always_comb begin
    idx_nxt = idx;
    if (MSB_FIRST) idx_nxt = idx - IDX_W'(1);
    else           idx_nxt = idx + IDX_W'(1);
  end

  // FSM with all outputs registered alongside state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      word        <= '0;
      idx         <= '0;
      in_ready_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.in_valid && in_ready_q) begin
            // ser_ready is irrelevant here: no bit is valid until the next cycle.
            word        <= bus.in_data;
            idx         <= FIRST_IDX;
            ser_bit_q   <= bus.in_data[FIRST_IDX];
            ser_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state       <= ST_SHIFT;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.ser_ready) begin
            if (idx == LAST_IDX) begin
              ser_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state       <= ST_DONE;
            end else begin
              idx       <= idx_nxt;
              ser_bit_q <= word[idx_nxt];
            end
          end
        end
        ST_DONE: begin
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          ser_valid_q <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_bit   = ser_bit_q;
  assign bus.ser_idx   = idx;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench: three serializer instances (8-bit LSB-first,
// 8-bit MSB-first, 4-bit LSB-first) sharing one clock and reset.
module tb_bit_serializer;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bit_serializer_if #(.WIDTH(8)) if_a ();
  bit_serializer_if #(.WIDTH(8)) if_b ();
  bit_serializer_if #(.WIDTH(4)) if_c ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_c (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word to instance A with ser_ready held high and check the whole frame.
  task automatic send_check_a(input string tag, input logic [7:0] w);
    check({tag, "_rdy"}, 32'(if_a.in_ready), 32'd1);
    if_a.in_data   = w;
    if_a.in_valid  = 1'b1;
    if_a.ser_ready = 1'b1;
    tick();
    if_a.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_v%0d", tag, i),   32'(if_a.ser_valid), 32'd1);
      check($sformatf("%s_idx%0d", tag, i), 32'(if_a.ser_idx),   32'(i));
      check($sformatf("%s_bit%0d", tag, i), 32'(if_a.ser_bit),   32'(w[i]));
      check($sformatf("%s_nd%0d", tag, i), 32'(if_a.done),      32'd0);
      tick();
    end
    check({tag, "_done"},   32'(if_a.done),      32'd1);
    check({tag, "_dvalid"}, 32'(if_a.ser_valid), 32'd0);
    check({tag, "_drdy"},   32'(if_a.in_ready),  32'd0);
    check({tag, "_dbusy"},  32'(if_a.busy),      32'd1);
    tick();
    check({tag, "_done0"},  32'(if_a.done),      32'd0);
    check({tag, "_rdy1"},   32'(if_a.in_ready),  32'd1);
    check({tag, "_busy0"},  32'(if_a.busy),      32'd0);
  endtask

  initial begin
    logic [7:0] wb;
    logic [7:0] wf;
    logic [3:0] wc;
    logic [7:0] exp_idx;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    if_a.in_data = '0; if_a.in_valid = 1'b0; if_a.ser_ready = 1'b0;
    if_b.in_data = '0; if_b.in_valid = 1'b0; if_b.ser_ready = 1'b0;
    if_c.in_data = '0; if_c.in_valid = 1'b0; if_c.ser_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_rdy",   32'(if_a.in_ready),  32'd0);
    check("rst_valid", 32'(if_a.ser_valid), 32'd0);
    check("rst_done",  32'(if_a.done),      32'd0);
    check("rst_busy",  32'(if_a.busy),      32'd0);
    check("rst_idx",   32'(if_a.ser_idx),   32'd0);
    reset = 1'b0;
    tick();
    check("rel_rdy_a", 32'(if_a.in_ready), 32'd1);
    check("rel_rdy_b", 32'(if_b.in_ready), 32'd1);
    check("rel_rdy_c", 32'(if_c.in_ready), 32'd1);

    // 1: LSB-first A5
    send_check_a("t1", 8'hA5);

    // 2: MSB-first 81
    wb = 8'h81;
    if_b.in_data = wb; if_b.in_valid = 1'b1; if_b.ser_ready = 1'b1;
    tick();
    if_b.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_idx%0d", i), 32'(if_b.ser_idx), 32'(7 - i));
      check($sformatf("t2_bit%0d", i), 32'(if_b.ser_bit), 32'(wb[7 - i]));
      check($sformatf("t2_nd%0d", i),  32'(if_b.done),    32'd0);
      tick();
    end
    check("t2_done",  32'(if_b.done), 32'd1);
    tick();
    check("t2_done0", 32'(if_b.done),     32'd0);
    check("t2_rdy",   32'(if_b.in_ready), 32'd1);

    // 3: 0F with ser_ready low for 3 cycles at idx 3
    wf = 8'h0F;
    if_a.in_data = wf; if_a.in_valid = 1'b1; if_a.ser_ready = 1'b1;
    tick();
    if_a.in_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 3)      exp_idx = 8'(c - 1);
      else if (c <= 7) exp_idx = 8'd3;
      else             exp_idx = 8'(c - 4);
      check($sformatf("t3_v%0d", c),   32'(if_a.ser_valid), 32'd1);
      check($sformatf("t3_idx%0d", c), 32'(if_a.ser_idx),   32'(exp_idx));
      check($sformatf("t3_bit%0d", c), 32'(if_a.ser_bit),   32'(wf[exp_idx[2:0]]));
      if_a.ser_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      tick();
    end
    check("t3_done",  32'(if_a.done),      32'd1);
    check("t3_valid", 32'(if_a.ser_valid), 32'd0);
    tick();
    check("t3_done0", 32'(if_a.done), 32'd0);

    // 4: in_valid held high with new data during SHIFT
    wf = 8'hF0;
    if_a.in_data = wf; if_a.in_valid = 1'b1; if_a.ser_ready = 1'b1;
    tick();
    if_a.in_data = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_idx%0d", i), 32'(if_a.ser_idx),  32'(i));
      check($sformatf("t4_bit%0d", i), 32'(if_a.ser_bit),  32'(wf[i]));
      check($sformatf("t4_rdy%0d", i), 32'(if_a.in_ready), 32'd0);
      tick();
    end
    check("t4_done",   32'(if_a.done),     32'd1);
    check("t4_drdy",   32'(if_a.in_ready), 32'd0);
    tick();
    check("t4_idle",   32'(if_a.in_ready),  32'd1);
    check("t4_idlev",  32'(if_a.ser_valid), 32'd0);
    tick();
    if_a.in_valid = 1'b0;
    wf = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4b_idx%0d", i), 32'(if_a.ser_idx), 32'(i));
      check($sformatf("t4b_bit%0d", i), 32'(if_a.ser_bit), 32'(wf[i]));
      tick();
    end
    check("t4b_done", 32'(if_a.done), 32'd1);
    tick();
    check("t4b_rdy",  32'(if_a.in_ready), 32'd1);

    // 5: async reset at idx 4 of FF
    if_a.in_data = 8'hFF; if_a.in_valid = 1'b1; if_a.ser_ready = 1'b1;
    tick();
    if_a.in_valid = 1'b0;
    repeat (4) tick();
    check("t5_idx4", 32'(if_a.ser_idx), 32'd4);
    #1 reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(if_a.ser_valid), 32'd0);
    check("t5_async_busy",  32'(if_a.busy),      32'd0);
    check("t5_async_rdy",   32'(if_a.in_ready),  32'd0);
    tick();
    tick();
    check("t5_nodone", 32'(if_a.done), 32'd0);
    reset = 1'b0;
    tick();
    check("t5_nodone2", 32'(if_a.done),      32'd0);
    check("t5_valid0",  32'(if_a.ser_valid), 32'd0);
    send_check_a("t5", 8'h01);

    // 6: 4-bit instance, C
    wc = 4'hC;
    if_c.in_data = wc; if_c.in_valid = 1'b1; if_c.ser_ready = 1'b1;
    tick();
    if_c.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_idx%0d", i), 32'(if_c.ser_idx), 32'(i));
      check($sformatf("t6_bit%0d", i), 32'(if_c.ser_bit), 32'(wc[i]));
      tick();
    end
    check("t6_done", 32'(if_c.done), 32'd1);
    tick();
    check("t6_rdy",  32'(if_c.in_ready), 32'd1);
    check("t6_done0", 32'(if_c.done),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
